// File: rtl/seq_alu_if.sv
// Op request / completion bundle between the PI control sequencer (master) and seq_alu (slave).
interface seq_alu_if #(
    parameter int DW = 16
);
    logic          start;
    logic [1:0]    op;
    logic          saturate;
    logic          mult2;
    logic          mult4;
    logic [DW-1:0] src0;
    logic [DW-1:0] src1;
    logic          busy;
    logic          done;
    logic [DW-1:0] dst;
    logic          ovf;

    modport master (
        output start, op, saturate, mult2, mult4, src0, src1,
        input  busy, done, dst, ovf
    );

    modport slave (
        input  start, op, saturate, mult2, mult4, src0, src1,
        output busy, done, dst, ovf
    );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle saturating add/sub, iterative Q-format signed multiply (one bit per clock).
// Optional macro ROUND_EN: round-half-up the product before windowing; otherwise the product is truncated.
module seq_alu #(
    parameter int DW      = 16,
    parameter int SAT_ADD = 12,
    parameter int MFRAC   = 12
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_alu_if.slave bus
);

    localparam int AW = DW + 3;      // add/sub working width
    localparam int MW = DW - 1;      // multiply operand width
    localparam int PW = 2 * MW;      // full product width
    localparam int RW = PW + 1;      // product plus headroom for the rounding add
    localparam int CW = $clog2(DW);

    localparam logic [DW-1:0] ADD_MAX = DW'((1 << (SAT_ADD - 1)) - 1);
    localparam logic [DW-1:0] ADD_MIN = ~ADD_MAX;
    localparam logic [DW-1:0] MUL_MAX = DW'((1 << (DW - 2)) - 1);
    localparam logic [DW-1:0] MUL_MIN = ~MUL_MAX;
    localparam logic [CW-1:0] LAST    = CW'(MW - 1);
`ifdef ROUND_EN
    localparam logic [RW-1:0] RND_HALF = RW'(1) << (MFRAC - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_FIN
    } state_t;

    state_t        state_q,  state_d;
    logic          busy_q,   busy_d;
    logic          done_q,   done_d;
    logic          ovf_q,    ovf_d;
    logic [DW-1:0] dst_q,    dst_d;
    logic [PW-1:0] prod_q,   prod_d;
    logic [PW-1:0] mcand_q,  mcand_d;
    logic [MW-1:0] mplier_q, mplier_d;
    logic [CW-1:0] cnt_q,    cnt_d;

    // ---------------- add / sub datapath (evaluated on the start cycle) ----------------
    logic [AW-1:0] a0_ext;
    logic [AW-1:0] a1_ext;
    logic [AW-1:0] a0_scaled;
    logic [AW-1:0] as_res;
    logic [AW-SAT_ADD:0] as_top;
    logic          as_in_range;
    logic [DW-1:0] as_dst;
    logic          as_ovf;

    always_comb begin
        a0_ext = {{3{bus.src0[DW-1]}}, bus.src0};
        a1_ext = {{3{bus.src1[DW-1]}}, bus.src1};
        if (bus.mult2) begin
            a0_scaled = a0_ext << 1;
        end else if (bus.mult4) begin
            a0_scaled = a0_ext << 2;
        end else begin
            a0_scaled = a0_ext;
        end
        as_res = (bus.op == 2'b01) ? (a1_ext - a0_scaled) : (a1_ext + a0_scaled);

        // In range when every bit from the SAT_ADD sign position upward agrees.
        as_top      = as_res[AW-1:SAT_ADD-1];
        as_in_range = (&as_top) || !(|as_top);
        as_dst      = as_res[DW-1:0];
        as_ovf      = 1'b0;
        if (bus.saturate && !as_in_range) begin
            as_ovf = 1'b1;
            as_dst = as_res[AW-1] ? ADD_MIN : ADD_MAX;
        end
    end

    // ---------------- multiply result windowing ----------------
    logic [RW-1:0]        rnd_w;
    logic signed [RW-1:0] rnd_shift;
    logic [RW-MW:0]       mul_top;
    logic                 mul_in_range;
    logic [DW-1:0]        mul_dst;
    logic                 mul_ovf;

    always_comb begin
`ifdef ROUND_EN
        rnd_w = {prod_q[PW-1], prod_q} + RND_HALF;
`else
        rnd_w = {prod_q[PW-1], prod_q};
`endif
        rnd_shift    = $signed(rnd_w) >>> MFRAC;
        mul_top      = rnd_shift[RW-1:MW-1];
        mul_in_range = (&mul_top) || !(|mul_top);
        mul_dst      = {rnd_shift[MW-1], rnd_shift[MW-1:0]};
        mul_ovf      = 1'b0;
        if (!mul_in_range) begin
            mul_ovf = 1'b1;
            mul_dst = rnd_shift[RW-1] ? MUL_MIN : MUL_MAX;
        end
    end

    // ---------------- control ----------------
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dst_d    = dst_q;
        ovf_d    = ovf_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.op == 2'b10) begin
                        state_d  = S_MUL;
                        busy_d   = 1'b1;
                        prod_d   = '0;
                        cnt_d    = '0;
                        mcand_d  = {{MW{bus.src0[MW-1]}}, bus.src0[MW-1:0]};
                        mplier_d = bus.src1[MW-1:0];
                    end else begin
                        done_d = 1'b1;
                        dst_d  = as_dst;
                        ovf_d  = as_ovf;
                    end
                end
            end

            S_MUL: begin
                // Sign-corrected shift-add: the multiplier's sign bit carries weight -2^(MW-1).
                if (mplier_q[0]) begin
                    prod_d = (cnt_q == LAST) ? (prod_q - mcand_q) : (prod_q + mcand_q);
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_FIN;
                    busy_d  = 1'b0;
                end
            end

            S_FIN: begin
                // Product is complete; a start seen here is not taken.
                done_d  = 1'b1;
                dst_d   = mul_dst;
                ovf_d   = mul_ovf;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            dst_q    <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            dst_q    <= dst_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.dst  = dst_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: arithmetic reference model checked every cycle, directed literal cases, random traffic.
module tb_seq_alu;

    localparam int DW      = 16;
    localparam int SAT_ADD = 12;
    localparam int MFRAC   = 12;

    localparam longint SAT_HI = (longint'(1) <<< (SAT_ADD - 1)) - 1;
    localparam longint SAT_LO = -(longint'(1) <<< (SAT_ADD - 1));
    localparam longint MUL_HI = (longint'(1) <<< (DW - 2)) - 1;
    localparam longint MUL_LO = -(longint'(1) <<< (DW - 2));

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    bit   checking = 1'b0;
    int   total    = 0;
    int   bad      = 0;

    seq_alu_if #(.DW(DW)) bus ();

    seq_alu #(.DW(DW), .SAT_ADD(SAT_ADD), .MFRAC(MFRAC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void model_addsub(input logic [1:0] op, input logic sat, input logic m2,
                                         input logic m4, input logic [DW-1:0] s0,
                                         input logic [DW-1:0] s1, output logic [DW-1:0] d,
                                         output logic o);
        longint a, b, r;
        a = longint'($signed(s0));
        b = longint'($signed(s1));
        if (m2)      a = a * 2;
        else if (m4) a = a * 4;
        r = (op == 2'b01) ? (b - a) : (b + a);
        o = 1'b0;
        if (sat && r > SAT_HI) begin
            r = SAT_HI; o = 1'b1;
        end else if (sat && r < SAT_LO) begin
            r = SAT_LO; o = 1'b1;
        end
        d = r[DW-1:0];
    endfunction

    function automatic void model_mul(input logic [DW-1:0] s0, input logic [DW-1:0] s1,
                                      output logic [DW-1:0] d, output logic o);
        longint a, b, p, q;
        a = longint'($signed(s0[DW-2:0]));
        b = longint'($signed(s1[DW-2:0]));
        p = a * b;
`ifdef ROUND_EN
        p = p + (longint'(1) <<< (MFRAC - 1));
`endif
        q = p >>> MFRAC;
        o = 1'b0;
        if (q > MUL_HI) begin
            q = MUL_HI; o = 1'b1;
        end else if (q < MUL_LO) begin
            q = MUL_LO; o = 1'b1;
        end
        d = q[DW-1:0];
    endfunction

    // Expected outputs after each edge; a multiply completes DW edges after it is accepted.
    int            mul_left = 0;
    logic          m_busy   = 1'b0;
    logic          m_done   = 1'b0;
    logic          m_ovf    = 1'b0;
    logic [DW-1:0] m_dst    = '0;
    logic          pend_ovf = 1'b0;
    logic [DW-1:0] pend_dst = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_left = 0;
            m_busy   = 1'b0;
            m_done   = 1'b0;
            m_ovf    = 1'b0;
            m_dst    = '0;
        end else begin
            m_done = 1'b0;
            if (mul_left > 0) begin
                mul_left--;
                if (mul_left == 0) begin
                    m_done = 1'b1;
                    m_dst  = pend_dst;
                    m_ovf  = pend_ovf;
                end
            end else if (bus.start) begin
                if (bus.op == 2'b10) begin
                    model_mul(bus.src0, bus.src1, pend_dst, pend_ovf);
                    mul_left = DW;
                end else begin
                    model_addsub(bus.op, bus.saturate, bus.mult2, bus.mult4,
                                 bus.src0, bus.src1, m_dst, m_ovf);
                    m_done = 1'b1;
                end
            end
            m_busy = (mul_left > 1);
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("busy", 32'(bus.busy), 32'(m_busy));
            check("done", 32'(bus.done), 32'(m_done));
            check("dst",  32'(bus.dst),  32'(m_dst));
            check("ovf",  32'(bus.ovf),  32'(m_ovf));
            if (bus.done) $display("txn done: dst=%h ovf=%b t=%0t", bus.dst, bus.ovf, $time);
        end
    end

    // ---------------- directed transaction with literal expectations ----------------
    task automatic run_op(input string name, input logic [1:0] op, input logic sat,
                          input logic m2, input logic m4, input logic [DW-1:0] s0,
                          input logic [DW-1:0] s1, input logic [DW-1:0] want_dst,
                          input logic want_ovf, input int want_edges, input int want_busy,
                          input int poke_at);
        int edges;
        int busy_cnt;
        edges    = 0;
        busy_cnt = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.saturate = sat;
        bus.mult2 = m2; bus.mult4 = m4; bus.src0 = s0; bus.src1 = s1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            bus.start = (n == poke_at);
            if (n == 1) begin
                bus.src0 = DW'($urandom); bus.src1 = DW'($urandom);
                bus.saturate = ~sat; bus.mult2 = ~m2; bus.mult4 = ~m4;
            end
            if (n == poke_at) bus.op = 2'b00;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                edges = n;
                break;
            end
        end
        bus.start = 1'b0;
        if (edges == 0) begin
            total++;
            bad++;
            $display("FAIL %s timeout: got no done want done within 40 edges", name);
        end else begin
            check({name, ".dst"},   32'(bus.dst), 32'(want_dst));
            check({name, ".ovf"},   32'(bus.ovf), 32'(want_ovf));
            check({name, ".edges"}, 32'(edges),   32'(want_edges));
            check({name, ".busy"},  32'(busy_cnt), 32'(want_busy));
        end
    endtask

    function automatic logic [DW-1:0] rand_operand();
        case ($urandom_range(0, 3))
            0:       return DW'($urandom);
            1:       return DW'($urandom_range(0, 16'h1FFF));
            2:       return ~DW'($urandom_range(0, 16'h1FFF));
            default: return DW'($urandom_range(0, 16'h0FFF)) ^ 16'h8000;
        endcase
    endfunction

    initial begin
        logic [DW-1:0] rnd_want;
        bus.start = 1'b0; bus.op = 2'b00; bus.saturate = 1'b0;
        bus.mult2 = 1'b0; bus.mult4 = 1'b0; bus.src0 = '0; bus.src1 = '0;
        repeat (3) @(posedge clk);
        checking = 1'b1;
        #1;
        check("reset.busy", 32'(bus.busy), 32'd0);
        check("reset.done", 32'(bus.done), 32'd0);
        check("reset.dst",  32'(bus.dst),  32'd0);
        check("reset.ovf",  32'(bus.ovf),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // name            op     sat   m2    m4    src0      src1      dst       ovf  edges busy poke
        run_op("add",      2'b00, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0200, 16'h0300, 1'b0, 1,  0, 0);
        run_op("sub_sat",  2'b01, 1'b1, 1'b0, 1'b0, 16'h0200, 16'hF900, 16'hF800, 1'b1, 1,  0, 0);
        run_op("sub_x2",   2'b01, 1'b1, 1'b1, 1'b0, 16'h0100, 16'h0000, 16'hFE00, 1'b0, 1,  0, 0);
        run_op("add_x4",   2'b00, 1'b0, 1'b0, 1'b1, 16'h4000, 16'h0001, 16'h0001, 1'b0, 1,  0, 0);
        run_op("sat_edge", 2'b00, 1'b1, 1'b0, 1'b0, 16'h07FF, 16'h0000, 16'h07FF, 1'b0, 1,  0, 0);
        run_op("sat_over", 2'b00, 1'b1, 1'b0, 1'b0, 16'h0800, 16'h0000, 16'h07FF, 1'b1, 1,  0, 0);
        run_op("op11_add", 2'b11, 1'b0, 1'b0, 1'b0, 16'h0005, 16'h0003, 16'h0008, 1'b0, 1,  0, 0);
        run_op("x2_prio",  2'b00, 1'b0, 1'b1, 1'b1, 16'h0001, 16'h0000, 16'h0002, 1'b0, 1,  0, 0);
        run_op("mul_half", 2'b10, 1'b1, 1'b1, 1'b0, 16'h1000, 16'h0800, 16'h0800, 1'b0, 17, 15, 0);
        run_op("mul_neg",  2'b10, 1'b0, 1'b0, 1'b0, 16'h7000, 16'h3000, 16'hD000, 1'b0, 17, 15, 0);
        run_op("mul_poke", 2'b10, 1'b0, 1'b0, 1'b0, 16'h1000, 16'h0800, 16'h0800, 1'b0, 17, 15, 5);
        run_op("mul_satn", 2'b10, 1'b0, 1'b0, 1'b0, 16'h3000, 16'h5000, 16'hC000, 1'b1, 17, 15, 0);
`ifdef ROUND_EN
        rnd_want = 16'h0001;
`else
        rnd_want = 16'h0000;
`endif
        run_op("mul_rnd",  2'b10, 1'b0, 1'b0, 1'b0, 16'h0001, 16'h0800, rnd_want, 1'b0, 17, 15, 0);
        run_op("mul_satp", 2'b10, 1'b0, 1'b0, 1'b0, 16'h3000, 16'h3000, 16'h3FFF, 1'b1, 17, 15, 0);

        // Reset in the middle of a multiply clears every output at once.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b10; bus.src0 = 16'h1000; bus.src1 = 16'h0800;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst.busy", 32'(bus.busy), 32'd0);
        check("arst.done", 32'(bus.done), 32'd0);
        check("arst.dst",  32'(bus.dst),  32'd0);
        check("arst.ovf",  32'(bus.ovf),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", 2'b00, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0020, 16'h0030, 1'b0, 1, 0, 0);

        // Back-to-back adds complete on consecutive cycles.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.saturate = 1'b0; bus.mult2 = 1'b0; bus.mult4 = 1'b0;
        bus.src0 = 16'h0001; bus.src1 = 16'h0002;
        @(posedge clk); #1;
        check("b2b.done1", 32'(bus.done), 32'd1);
        check("b2b.dst1",  32'(bus.dst),  32'h0003);
        bus.src0 = 16'h0003; bus.src1 = 16'h0004;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("b2b.done2", 32'(bus.done), 32'd1);
        check("b2b.dst2",  32'(bus.dst),  32'h0007);
        @(posedge clk); #1;
        check("b2b.done3", 32'(bus.done), 32'd0);

        // Random traffic, including starts while busy and in the final multiply cycle.
        repeat (1500) begin
            @(posedge clk); #1;
            bus.start    = ($urandom_range(0, 2) == 0);
            bus.op       = 2'($urandom);
            bus.saturate = 1'($urandom);
            bus.mult2    = ($urandom_range(0, 3) == 0);
            bus.mult4    = ($urandom_range(0, 3) == 0);
            bus.src0     = rand_operand();
            bus.src1     = rand_operand();
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (DW + 4) @(posedge clk);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
